// File: rtl/recover_encoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : recover_encoder_ctrl
// Purpose  : Arbitrates the forward/backward Fano searches onto the shared
//            parity re-encoder, routes results back by tag, and sequences
//            drain-then-reset reconfiguration. Optional orphan/overflow
//            checking is enabled by defining RENC_CTRL_CHECK_EN.
// Revision : 1.0
// ============================================================================
module recover_encoder_ctrl #(
    parameter int ENC_LATENCY = 8,
    parameter int RST_CYCLES  = 2,
    parameter int DATA_W      = 89
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_vld,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_rdy,
    input  logic              req1_vld,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_rdy,
    output logic              rsp0_vld,
    output logic              rsp1_vld,
    output logic [1:0]        rsp_rib_0,
    output logic [1:0]        rsp_rib_1,
    input  logic              cfg_update,
    input  logic [1:0]        cfg_code_rate,
    input  logic              cfg_diff_en,
    output logic              cfg_busy,
    output logic              enc_reset_n,
    output logic [1:0]        enc_code_rate,
    output logic              enc_diff_en,
    output logic              enc_vld,
    output logic [DATA_W-1:0] enc_data,
    input  logic              enc_o_vld,
    input  logic [1:0]        enc_rib_0,
    input  logic [1:0]        enc_rib_1
`ifdef RENC_CTRL_CHECK_EN
    ,
    output logic              err_orphan
`endif
);

    localparam int DEPTH = ENC_LATENCY + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_rst_cnt;
    logic               r_ptr;
    logic [1:0]         r_shadow_rate;
    logic               r_shadow_diff;
    logic [CNT_W-1:0]   r_inflight;
    logic [DEPTH-1:0]   r_tags;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic               r_enc_reset_n;
    logic [1:0]         r_enc_code_rate;
    logic               r_enc_diff_en;
    logic               r_enc_vld;
    logic [DATA_W-1:0]  r_enc_data;
    logic               r_rsp0_vld;
    logic               r_rsp1_vld;
    logic [1:0]         r_rsp_rib_0;
    logic [1:0]         r_rsp_rib_1;

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_acc;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_pop_tag;
    logic [PTR_W-1:0]   w_wr_next;
    logic [PTR_W-1:0]   w_rd_next;

    // A pending reconfiguration wins over arbitration in the same cycle.
    assign w_idle    = (r_state == S_IDLE) && !cfg_update;
    assign w_gnt0    = w_idle && req0_vld && (!req1_vld || !r_ptr);
    assign w_gnt1    = w_idle && req1_vld && (!req0_vld ||  r_ptr);
    assign w_acc     = w_gnt0 || w_gnt1;

    assign w_empty   = (r_inflight == '0);
    assign w_full    = (r_inflight == CNT_W'(DEPTH));
    assign w_pop     = enc_o_vld && r_enc_reset_n && !w_empty;
    assign w_push    = w_acc && (!w_full || w_pop);
    assign w_pop_tag = r_tags[r_rd_ptr];
    assign w_wr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_RESET;
            r_rst_cnt       <= 4'(RST_CYCLES);
            r_ptr           <= 1'b0;
            r_shadow_rate   <= 2'd0;
            r_shadow_diff   <= 1'b0;
            r_inflight      <= '0;
            r_tags          <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_enc_reset_n   <= 1'b0;
            r_enc_code_rate <= 2'd0;
            r_enc_diff_en   <= 1'b0;
            r_enc_vld       <= 1'b0;
            r_enc_data      <= '0;
            r_rsp0_vld      <= 1'b0;
            r_rsp1_vld      <= 1'b0;
            r_rsp_rib_0     <= 2'd0;
            r_rsp_rib_1     <= 2'd0;
        end else begin
            r_enc_vld <= w_acc;
            if (w_acc) begin
                r_enc_data <= w_gnt1 ? req1_data : req0_data;
                r_ptr      <= w_gnt0;
            end

            if (w_push) begin
                r_tags[r_wr_ptr] <= w_gnt1;
                r_wr_ptr         <= w_wr_next;
            end
            if (w_pop) begin
                r_rd_ptr    <= w_rd_next;
                r_rsp_rib_0 <= enc_rib_0;
                r_rsp_rib_1 <= enc_rib_1;
            end
            r_rsp0_vld <= w_pop && !w_pop_tag;
            r_rsp1_vld <= w_pop &&  w_pop_tag;

            if (w_push && !w_pop)
                r_inflight <= r_inflight + 1'b1;
            else if (w_pop && !w_push)
                r_inflight <= r_inflight - 1'b1;

            case (r_state)
                S_RESET: begin
                    r_rst_cnt <= r_rst_cnt - 1'b1;
                    if (r_rst_cnt <= 4'd1) begin
                        r_state       <= S_IDLE;
                        r_enc_reset_n <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cfg_update) begin
                        r_shadow_rate <= cfg_code_rate;
                        r_shadow_diff <= cfg_diff_en;
                        r_state       <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_enc_code_rate <= r_shadow_rate;
                        r_enc_diff_en   <= r_shadow_diff;
                        r_rst_cnt       <= 4'(RST_CYCLES);
                        r_enc_reset_n   <= 1'b0;
                        r_state         <= S_RESET;
                    end
                end
                default: r_state <= S_RESET;
            endcase
        end
    end

`ifdef RENC_CTRL_CHECK_EN
    logic r_err_orphan;

    // A full FIFO is legal when a result leaves in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_err_orphan <= 1'b0;
        else if ((enc_o_vld && r_enc_reset_n && w_empty) || (w_acc && w_full && !w_pop))
            r_err_orphan <= 1'b1;
    end

    assign err_orphan = r_err_orphan;
`endif

    assign req0_rdy      = w_gnt0;
    assign req1_rdy      = w_gnt1;
    assign cfg_busy      = (r_state != S_IDLE);
    assign enc_reset_n   = r_enc_reset_n;
    assign enc_code_rate = r_enc_code_rate;
    assign enc_diff_en   = r_enc_diff_en;
    assign enc_vld       = r_enc_vld;
    assign enc_data      = r_enc_data;
    assign rsp0_vld      = r_rsp0_vld;
    assign rsp1_vld      = r_rsp1_vld;
    assign rsp_rib_0     = r_rsp_rib_0;
    assign rsp_rib_1     = r_rsp_rib_1;

endmodule
`default_nettype wire

// File: tb/tb_recover_encoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_recover_encoder_ctrl
// Purpose  : Scoreboard bench for recover_encoder_ctrl with a behavioural
//            fixed-latency re-encoder. Define RENC_CTRL_CHECK_EN for err_orphan.
// Revision : 1.0
// ============================================================================
module tb_recover_encoder_ctrl;

    localparam int ENC_LATENCY = 8;
    localparam int RST_CYCLES  = 2;
    localparam int DATA_W      = 89;
    localparam int RSP_LAT     = ENC_LATENCY + 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req0_vld = 1'b0, req1_vld = 1'b0;
    logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
    logic              req0_rdy, req1_rdy;
    logic              rsp0_vld, rsp1_vld;
    logic [1:0]        rsp_rib_0, rsp_rib_1;
    logic              cfg_update = 1'b0;
    logic [1:0]        cfg_code_rate = 2'd0;
    logic              cfg_diff_en = 1'b0;
    logic              cfg_busy;
    logic              enc_reset_n;
    logic [1:0]        enc_code_rate;
    logic              enc_diff_en;
    logic              enc_vld;
    logic [DATA_W-1:0] enc_data;
    logic              enc_o_vld = 1'b0;
    logic [1:0]        enc_rib_0 = 2'd0, enc_rib_1 = 2'd0;
`ifdef RENC_CTRL_CHECK_EN
    logic              err_orphan;
`endif

    recover_encoder_ctrl #(
        .ENC_LATENCY (ENC_LATENCY),
        .RST_CYCLES  (RST_CYCLES),
        .DATA_W      (DATA_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req0_vld      (req0_vld),
        .req0_data     (req0_data),
        .req0_rdy      (req0_rdy),
        .req1_vld      (req1_vld),
        .req1_data     (req1_data),
        .req1_rdy      (req1_rdy),
        .rsp0_vld      (rsp0_vld),
        .rsp1_vld      (rsp1_vld),
        .rsp_rib_0     (rsp_rib_0),
        .rsp_rib_1     (rsp_rib_1),
        .cfg_update    (cfg_update),
        .cfg_code_rate (cfg_code_rate),
        .cfg_diff_en   (cfg_diff_en),
        .cfg_busy      (cfg_busy),
        .enc_reset_n   (enc_reset_n),
        .enc_code_rate (enc_code_rate),
        .enc_diff_en   (enc_diff_en),
        .enc_vld       (enc_vld),
        .enc_data      (enc_data),
        .enc_o_vld     (enc_o_vld),
        .enc_rib_0     (enc_rib_0),
        .enc_rib_1     (enc_rib_1)
`ifdef RENC_CTRL_CHECK_EN
        ,
        .err_orphan    (err_orphan)
`endif
    );

    typedef struct {
        logic [1:0] r0;
        logic [1:0] r1;
        int         due;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp0[$];
    exp_t exp1[$];
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];

    int rsp_seen = 0;
    int last_ovld_cyc = 0, fall_gap = -1, rise_cyc = -1, low_run = 0, last_low_run = -1;
    logic prev_rst_n = 1'b0;
    int acc_cnt0 = 0, acc_cnt1 = 0, prev_acc0 = -1;
    bit mode_consec = 0, mode_seq = 0, want_first = 0;
    int seq_idx = 0, first_acc_cyc = -1;
    int seq_exp[12] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic force_orphan = 1'b0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] rib0_of(logic [DATA_W-1:0] d);
        return d[1:0] ^ d[88:87];
    endfunction

    function automatic logic [1:0] rib1_of(logic [DATA_W-1:0] d);
        return d[3:2] ^ d[5:4];
    endfunction

    function automatic logic [DATA_W-1:0] word(int k, int i);
        logic [95:0] t;
        t = {32'(i * 7 + k * 3 + 1), 32'(i * 32'h9E3779B1), 32'(i ^ (k << 4) ^ 32'h5A)};
        return t[DATA_W-1:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Re-encoder model: fixed latency, cleared while held in reset.
    initial begin
        logic             mv[ENC_LATENCY];
        logic [DATA_W-1:0] md[ENC_LATENCY];
        for (int i = 0; i < ENC_LATENCY; i++) begin mv[i] = 1'b0; md[i] = '0; end
        forever begin
            @(posedge clk); #2;
            if (!enc_reset_n) begin
                for (int i = 0; i < ENC_LATENCY; i++) mv[i] = 1'b0;
                enc_o_vld = force_orphan;
                enc_rib_0 = force_orphan ? 2'b11 : 2'b00;
                enc_rib_1 = force_orphan ? 2'b11 : 2'b00;
            end else begin
                enc_o_vld = mv[ENC_LATENCY-1] | force_orphan;
                enc_rib_0 = force_orphan ? 2'b11 : rib0_of(md[ENC_LATENCY-1]);
                enc_rib_1 = force_orphan ? 2'b11 : rib1_of(md[ENC_LATENCY-1]);
                for (int i = ENC_LATENCY - 1; i > 0; i--) begin mv[i] = mv[i-1]; md[i] = md[i-1]; end
                mv[0] = enc_vld;
                md[0] = enc_data;
            end
        end
    end

    // Monitor: scoreboard pops on every response, plus arbitration rules.
    initial forever begin
        exp_t e;
        @(negedge clk);
        checks++;
        if ((req0_rdy && req1_rdy) || ((cfg_busy || cfg_update) && (req0_rdy || req1_rdy)) ||
            (req0_rdy && !req0_vld) || (req1_rdy && !req1_vld)) begin
            errors++;
            $display("FAIL grant_rule: rdy0=%0b rdy1=%0b busy=%0b upd=%0b (cycle %0d)",
                     req0_rdy, req1_rdy, cfg_busy, cfg_update, cyc);
        end
        if (rsp0_vld) begin
            rsp_seen++;
            if (exp0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
            else begin
                e = exp0.pop_front();
                chk("rsp0_rib", {rsp_rib_1, rsp_rib_0}, {e.r1, e.r0});
                chk("rsp0_cycle", cyc, e.due);
            end
        end
        if (rsp1_vld) begin
            rsp_seen++;
            if (exp1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
            else begin
                e = exp1.pop_front();
                chk("rsp1_rib", {rsp_rib_1, rsp_rib_0}, {e.r1, e.r0});
                chk("rsp1_cycle", cyc, e.due);
            end
        end
        if (enc_o_vld && enc_reset_n) last_ovld_cyc = cyc;
        if (!enc_reset_n) begin
            if (prev_rst_n) fall_gap = cyc - last_ovld_cyc;
            low_run++;
        end else begin
            if (!prev_rst_n) begin last_low_run = low_run; rise_cyc = cyc; end
            low_run = 0;
        end
        prev_rst_n = enc_reset_n;
    end

    task automatic drive();
        req0_vld  = (q0.size() > 0);
        req0_data = (q0.size() > 0) ? q0[0] : '0;
        req1_vld  = (q1.size() > 0);
        req1_data = (q1.size() > 0) ? q1[0] : '0;
    endtask

    task automatic note_acc(int k, logic [DATA_W-1:0] d);
        exp_t e;
        e.r0 = rib0_of(d);
        e.r1 = rib1_of(d);
        e.due = cyc + RSP_LAT;
        if (k == 0) begin exp0.push_back(e); acc_cnt0++; end
        else        begin exp1.push_back(e); acc_cnt1++; end
        if (mode_consec && k == 0) begin
            if (prev_acc0 >= 0) chk("consecutive_grant", cyc - prev_acc0, 32'd1);
            prev_acc0 = cyc;
        end
        if (mode_seq && seq_idx < 12) begin
            chk("alternate_grant", k, seq_exp[seq_idx]);
            seq_idx++;
        end
        if (want_first) begin first_acc_cyc = cyc; want_first = 0; end
    endtask

    task automatic tick();
        @(negedge clk);
        if (req0_rdy && q0.size() > 0) begin note_acc(0, q0[0]); void'(q0.pop_front()); end
        if (req1_rdy && q1.size() > 0) begin note_acc(1, q1[0]); void'(q1.pop_front()); end
        @(posedge clk); #1;
        drive();
    endtask

    task automatic wait_drain(string name, int limit);
        int n = 0;
        while ((q0.size() + q1.size() + exp0.size() + exp1.size()) != 0 && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) chk(name, 32'd1, 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enc_reset_n", enc_reset_n, 0);
        chk("rst_cfg_busy", cfg_busy, 1);
        chk("rst_enc_vld", enc_vld, 0);
        chk("rst_outputs", {enc_code_rate, enc_diff_en, rsp0_vld, rsp1_vld, rsp_rib_0, rsp_rib_1}, 0);
        reset_n = 1'b1;
        @(negedge clk); chk("rst_low_c1", enc_reset_n, 0);
        @(negedge clk); chk("rst_low_c2", enc_reset_n, 0);
                        chk("busy_c2", cfg_busy, 1);
        @(negedge clk); chk("rst_high_c3", enc_reset_n, 1);
                        chk("busy_drop_c3", cfg_busy, 0);
                        chk("rate_after_rst", enc_code_rate, 0);
        @(posedge clk); #1;

        // Single requester streaming.
        for (int i = 0; i < 20; i++) q0.push_back(word(0, i));
        drive();
        mode_consec = 1;
        wait_drain("drain_stream_timeout", 200);
        mode_consec = 0;
        chk("stream_accepts", acc_cnt0, 20);

        // Both requesters: pointer favours 1 after the last grant to 0.
        for (int i = 0; i < 6; i++) begin q0.push_back(word(0, 100 + i)); q1.push_back(word(1, 200 + i)); end
        drive();
        mode_seq = 1;
        wait_drain("drain_alt_timeout", 200);
        mode_seq = 0;
        chk("alt_accepts1", acc_cnt1, 6);

        // Reconfiguration with five results outstanding.
        for (int i = 0; i < 5; i++) q0.push_back(word(0, 300 + i));
        drive();
        n = 0;
        while (q0.size() != 0 && n < 50) begin tick(); n++; end
        for (int i = 0; i < 2; i++) q1.push_back(word(1, 400 + i));
        drive();
        cfg_update = 1'b1; cfg_code_rate = 2'd1; cfg_diff_en = 1'b1;
        want_first = 1;
        tick();
        chk("busy_in_drain", cfg_busy, 1);
        cfg_update = 1'b1; cfg_code_rate = 2'd2; cfg_diff_en = 1'b0;
        tick();
        cfg_update = 1'b0; cfg_code_rate = 2'd0;
        wait_drain("drain_cfg_timeout", 200);
        chk("cfg_code_rate", enc_code_rate, 1);
        chk("cfg_diff_en", enc_diff_en, 1);
        chk("cfg_reset_len", last_low_run, RST_CYCLES);
        chk("cfg_reset_after_last_result", (fall_gap >= 1 && fall_gap <= 2), 1);
        chk("grant_resumes_at_idle", first_acc_cyc, rise_cyc);

        // Orphan result with nothing in flight.
        rs = rsp_seen;
        force_orphan = 1'b1;
        tick();
        force_orphan = 1'b0;
        repeat (4) tick();
        chk("orphan_no_rsp", rsp_seen, rs);
`ifdef RENC_CTRL_CHECK_EN
        chk("err_orphan_set", err_orphan, 1);
        repeat (5) tick();
        chk("err_orphan_sticky", err_orphan, 1);
`endif

        // Asynchronous reset with work in flight discards every result.
        for (int i = 0; i < 3; i++) q0.push_back(word(0, 500 + i));
        drive();
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        chk("async_enc_reset_n", enc_reset_n, 0);
        chk("async_busy", cfg_busy, 1);
        chk("async_rate", enc_code_rate, 0);
`ifdef RENC_CTRL_CHECK_EN
        chk("err_orphan_clear", err_orphan, 0);
`endif
        exp0.delete();
        exp1.delete();
        q0.delete();
        drive();
        @(posedge clk); #1;
        reset_n = 1'b1;
        rs = rsp_seen;
        repeat (16) tick();
        chk("async_no_rsp", rsp_seen, rs);
        chk("async_idle", cfg_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
